// File: rtl/mips_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Provides the loader FSM state type, the default frame sync byte and
// the widths of the frame fields (byte, instruction word, length field).
package mips_boot_pkg;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned WORD_W            = 32;
    localparam int unsigned LEN_W             = 16;
    localparam int unsigned BYTES_PER_WORD    = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

endpackage

// File: rtl/mips_boot_word_assembler.sv
// Byte-to-word assembler for the boot loader.
// Shifts accepted payload bytes in MSB-first, counts bytes within a word,
// flags the byte that completes a word and keeps the running XOR checksum.
// Ports:
//   clk, reset      clock / synchronous active-low reset
//   clr             clear counter, shift register and checksum
//   byte_valid      a payload byte is accepted this cycle
//   byte_data       the payload byte
//   word_valid      this byte completes a word (combinational)
//   word            assembled word, valid with word_valid
//   csum            XOR of all payload bytes accepted so far
module mips_boot_word_assembler
    import mips_boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] csum
);

    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [BYTE_W-1:0]        csum_q, csum_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        if (byte_valid) begin
            shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_data};
            cnt_d   = cnt_q + 2'd1;
            csum_d  = csum_q ^ byte_data;
        end
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
            csum_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    // The fourth byte is taken straight from the input so the word is
    // complete in the same cycle it is accepted.
    assign word_valid = byte_valid && (cnt_q == 2'd3);
    assign word       = {shift_q, byte_data};
    assign csum       = csum_q;

endmodule

// File: rtl/mips_imem_boot_loader.sv
// Boot loader for main_mips: parses a framed byte stream
// (SYNC, N[15:8], N[7:0], 4*N big-endian data bytes, XOR checksum),
// writes the words to instruction memory from address 0 and releases
// the CPU reset only when the frame loaded with a matching checksum.
// Ports:
//   clk, reset              clock / synchronous active-low reset
//   in_valid/in_data/in_ready  byte stream handshake
//   restart                 leave DONE/ERROR and return to IDLE
//   imem_we/addr/wdata      one-cycle instruction-memory write
//   cpu_reset               active-high reset to the processor
//   done / error            frame accepted / rejected
//   words_loaded            words written in the current frame
module mips_imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 256,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    boot_state_e           state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [CNT_W-1:0]      words_q, words_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic             ready_int, accept, finished, clr, byte_valid;
    logic             word_valid, last_word;
    logic [31:0]      word;
    logic [7:0]       csum;
    logic [LEN_W-1:0] len;

    assign finished   = (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign ready_int  = reset && !finished;
    assign accept     = in_valid && ready_int;
    assign clr        = finished && restart;
    assign byte_valid = accept && (state_q == ST_DATA);
    assign len        = {len_hi_q, in_data};
    assign last_word  = (words_q == n_q - CNT_W'(1));

    mips_boot_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .byte_valid (byte_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        words_d  = words_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = word_valid;

        // Write is registered: strobe, address and data appear the cycle
        // after the word's fourth byte; words_loaded steps on that edge.
        if (word_valid) begin
            addr_d  = words_q[ADDR_WIDTH-1:0];
            wdata_d = word;
            words_d = words_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len == '0) begin
                        state_d = ST_CSUM;
                    end else if (32'(len) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = len[CNT_W-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid && last_word) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_d = (in_data == csum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_d  = ST_IDLE;
                    len_hi_d = '0;
                    n_d      = '0;
                    words_d  = '0;
                    addr_d   = '0;
                    wdata_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            len_hi_q <= '0;
            n_q      <= '0;
            words_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            n_q      <= n_d;
            words_q  <= words_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign in_ready     = ready_int;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_mips_imem_boot_loader.sv
// Self-checking bench for mips_imem_boot_loader: builds frames from word
// lists, derives the expected writes and checksum from the frame rules,
// and compares the captured memory writes and status outputs.
module tb_mips_imem_boot_loader;

    localparam int unsigned AW    = 8;
    localparam int unsigned MAXW  = 256;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          restart = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset, done, error;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t         wq[$];
    logic [31:0] fw[MAXW];

    mips_imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .SYNC_BYTE(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wq.push_back('{imem_addr, imem_wdata});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned w = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err,
                                input int exp_words);
        chk({tag, "_done"},      {63'd0, done},      {63'd0, exp_done});
        chk({tag, "_error"},     {63'd0, error},     {63'd0, exp_err});
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, {63'd0, !exp_done});
        chk({tag, "_words"},     64'(words_loaded),  64'(exp_words));
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
    endtask

    // Sends a whole frame of n words from fw[], checksum XORed with flip.
    task automatic run_frame(input string tag, input int n, input logic [7:0] flip,
                             input bit mid_restart);
        logic [7:0] x = '0;
        logic [7:0] b;
        wq.delete();
        send_byte(SYNC);
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = fw[i][31 - 8*k -: 8];
                x ^= b;
                send_byte(b);
                if (mid_restart && i == 0 && k == 1) begin
                    @(negedge clk) restart = 1'b1;
                    @(posedge clk);
                    #1 restart = 1'b0;
                end
            end
        end
        send_byte(x ^ flip);
        @(negedge clk);
        check_status(tag, flip == 8'h00, flip != 8'h00, n);
        chk({tag, "_wr_count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(wq[i].a), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), 64'(wq[i].d), 64'(fw[i]));
        end
    endtask

    task automatic do_restart(input string tag, input bit with_byte);
        @(negedge clk);
        restart = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = SYNC;
        end
        @(posedge clk);
        #1 restart = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done"},      {63'd0, done},      64'd0);
        chk({tag, "_error"},     {63'd0, error},     64'd0);
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
        chk({tag, "_words"},     64'(words_loaded),  64'd0);
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},        {63'd0, imem_we},   64'd0);
        chk({tag, "_addr"},      64'(imem_addr),     64'd0);
        chk({tag, "_wdata"},     64'(imem_wdata),    64'd0);
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
        chk({tag, "_done"},      {63'd0, done},      64'd0);
        chk({tag, "_error"},     {63'd0, error},     64'd0);
        chk({tag, "_words"},     64'(words_loaded),  64'd0);
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
    endtask

    initial begin
        int n;
        logic [7:0] flip;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        #1 chk("rst_release_ready", {63'd0, in_ready}, 64'd1);

        // Two-word frame, good then bad checksum
        fw[0] = 32'h20080005;
        fw[1] = 32'h20090007;
        run_frame("two_ok", 2, 8'h00, 1'b0);
        do_restart("rs1", 1'b0);
        run_frame("two_bad", 2, 8'h01, 1'b0);

        // Restart with a byte offered in the same cycle: byte must be dropped,
        // so the following N=0 frame parses cleanly.
        do_restart("rs_byte", 1'b1);
        run_frame("n0", 0, 8'h00, 1'b0);
        do_restart("rs2", 1'b0);

        // Garbage ahead of a one-word frame
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        fw[0] = 32'h00000000;
        run_frame("garbage", 1, 8'h00, 1'b0);
        do_restart("rs3", 1'b0);

        // Oversized length is rejected right after the low length byte
        wq.delete();
        send_byte(SYNC);
        send_byte(8'(((MAXW + 1) >> 8)));
        send_byte(8'(MAXW + 1));
        @(negedge clk);
        check_status("oversize", 1'b0, 1'b1, 0);
        chk("oversize_wr_count", 64'(wq.size()), 64'd0);
        do_restart("rs4", 1'b0);

        // Reset mid-frame, two bytes into word 1
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        fw[0] = $urandom;
        fw[1] = $urandom;
        run_frame("after_rst", 2, 8'h00, 1'b0);
        do_restart("rs5", 1'b0);

        // Restart while loading is ignored
        for (int i = 0; i < 3; i++) fw[i] = $urandom;
        run_frame("mid_restart", 3, 8'h00, 1'b1);
        do_restart("rs6", 1'b0);

        // Largest frame: last address is MAX_WORDS-1
        for (int i = 0; i < MAXW; i++) fw[i] = $urandom;
        run_frame("maxw", MAXW, 8'h00, 1'b0);
        do_restart("rs7", 1'b0);

        // Random frames, some with corrupted checksum
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) fw[i] = $urandom;
            flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame($sformatf("rnd%0d", f), n, flip, 1'b0);
            do_restart($sformatf("rnd_rs%0d", f), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
